// File: rtl/marsohod_wb_arb2.sv
// Two-master Wishbone arbiter: round-robin grant held for the whole cycle,
// stall watchdog that aborts a hung slave access with a one-cycle error.
module marsohod_wb_arb2 #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clock,
   input  logic            reset_n,
   // master 0 request / response
   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_we_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic [DW-1:0]   m0_dat_o,
   output logic            m0_ack_o,
   output logic            m0_err_o,
   // master 1 request / response
   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_we_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic [DW-1:0]   m1_dat_o,
   output logic            m1_ack_o,
   output logic            m1_err_o,
   // shared slave
   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_we_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic [DW-1:0]   s_dat_i,
   input  logic            s_ack_i,
   input  logic            s_err_i,
   // status
   output logic [1:0]      gnt_o,
   output logic            timeout_o
);

   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GNT0   = 3'd1,
      GNT1   = 3'd2,
      ABORT0 = 3'd3,
      ABORT1 = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   logic        last_q,  last_d;   // 1: m1 was served last, so m0 wins the next tie

   logic        owner_m1;
   logic        own_cyc;
   logic        own_stb;

   assign owner_m1 = (state_q == GNT1) || (state_q == ABORT1);
   assign own_cyc  = owner_m1 ? m1_cyc_i : m0_cyc_i;
   assign own_stb  = owner_m1 ? m1_stb_i : m0_stb_i;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      stall_d = stall_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            stall_d = '0;
            if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_d = GNT0;
            else if (m1_cyc_i)        state_d = GNT1;
         end
         GNT0, GNT1: begin
            if (!own_cyc) begin
               state_d = IDLE;
               stall_d = '0;
               last_d  = owner_m1;
            end else if (s_ack_i || s_err_i || !own_stb) begin
               stall_d = '0;
            end else if (stall_q == STALL_LIMIT) begin
               state_d = owner_m1 ? ABORT1 : ABORT0;
               stall_d = '0;
            end else begin
               stall_d = stall_q + 16'd1;
            end
         end
         ABORT0: begin
            stall_d = '0;
            if (m0_cyc_i) state_d = GNT0;
            else begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         ABORT1: begin
            stall_d = '0;
            if (m1_cyc_i) state_d = GNT1;
            else begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            stall_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         stall_q <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         last_q  <= last_d;
      end
   end

   // Routing is decoded from the registered state only, so reset clears it at once.
   always_comb begin
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_we_o    = 1'b0;
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      m0_dat_o  = '0;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_dat_o  = '0;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      gnt_o     = 2'b00;
      timeout_o = 1'b0;
      unique case (state_q)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
            gnt_o    = 2'b01;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
            gnt_o    = 2'b10;
         end
         ABORT0: begin
            m0_err_o  = 1'b1;
            gnt_o     = 2'b01;
            timeout_o = 1'b1;
         end
         ABORT1: begin
            m1_err_o  = 1'b1;
            gnt_o     = 2'b10;
            timeout_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_marsohod_wb_arb2.sv
// Self-checking bench for marsohod_wb_arb2: directed scenarios plus a response
// scoreboard that expects every master ack/err the bench provokes, and no others.
module tb_marsohod_wb_arb2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [AW-1:0]   m0_adr_i, m1_adr_i;
   logic [DW-1:0]   m0_dat_i, m1_dat_i;
   logic [DW/8-1:0] m0_sel_i, m1_sel_i;
   logic            m0_we_i, m0_cyc_i, m0_stb_i;
   logic            m1_we_i, m1_cyc_i, m1_stb_i;
   logic [DW-1:0]   m0_dat_o, m1_dat_o;
   logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o;
   logic [DW/8-1:0] s_sel_o;
   logic            s_we_o, s_cyc_o, s_stb_o;
   logic [DW-1:0]   s_dat_i;
   logic            s_ack_i, s_err_i;
   logic [1:0]      gnt_o;
   logic            timeout_o;

   int checks = 0;
   int errors = 0;

   // Expected response vectors: {m1_ack, m1_err, m1_dat, m0_ack, m0_err, m0_dat}
   logic [2*DW+3:0] sb[$];
   logic [2*DW+3:0] mon_got;

   marsohod_wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset_n(reset_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*DW+3:0] resp(input bit m1, input bit ack, input bit err,
                                            input logic [DW-1:0] dat);
      if (m1) return {ack, err, dat, 1'b0, 1'b0, {DW{1'b0}}};
      return {1'b0, 1'b0, {DW{1'b0}}, ack, err, dat};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic master(input bit m1, input bit cyc, input logic [AW-1:0] adr);
      if (m1) begin
         m1_cyc_i = cyc; m1_stb_i = cyc; m1_adr_i = adr;
      end else begin
         m0_cyc_i = cyc; m0_stb_i = cyc; m0_adr_i = adr;
      end
   endtask

   // Slave ack for the current cycle; the bench states which master must receive it.
   task automatic slave_ack(input bit to_m1, input logic [DW-1:0] dat);
      s_ack_i = 1'b1;
      s_dat_i = dat;
      sb.push_back(resp(to_m1, 1'b1, 1'b0, dat));
   endtask

   // Any master response is compared against the oldest expectation.
   always @(negedge clock) begin
      if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
         mon_got = {m1_ack_o, m1_err_o, m1_dat_o, m0_ack_o, m0_err_o, m0_dat_o};
         if (sb.size() == 0) check("sb_unexpected", 128'(mon_got), 128'(0));
         else                check("sb_resp", 128'(mon_got), 128'(sb.pop_front()));
      end
   end

   initial begin
      reset_n  = 1'b1;
      m0_adr_i = '0; m0_dat_i = 32'h1111_0000; m0_sel_i = 4'hF; m0_we_i = 1'b0;
      m1_adr_i = '0; m1_dat_i = 32'h2222_0000; m1_sel_i = 4'h3; m1_we_i = 1'b1;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      s_dat_i  = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

      #2 reset_n = 1'b0;
      #1;
      check("rst_gnt", 128'(gnt_o), 128'(0));
      check("rst_timeout", 128'(timeout_o), 128'(0));
      check("rst_s_req", 128'({s_cyc_o, s_stb_o, s_we_o, s_adr_o}), 128'(0));
      check("rst_m_resp", 128'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o}), 128'(0));
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;

      // Single master, slave acks in the third granted cycle
      master(0, 1, 32'h100);
      @(negedge clock) check("t1_arb_latency", 128'(gnt_o), 128'(2'b00));
      tick();
      @(negedge clock);
      check("t1_gnt", 128'(gnt_o), 128'(2'b01));
      check("t1_s_adr", 128'(s_adr_o), 128'(32'h100));
      check("t1_s_req", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_dat_o}), 128'({3'b110, 4'hF, 32'h1111_0000}));
      tick();
      tick();
      slave_ack(0, 32'hCAFE_0001);
      @(negedge clock) check("t1_ack_same_cycle", 128'(m0_ack_o), 128'(1));
      tick();
      s_ack_i = 1'b0;
      master(0, 0, 32'h100);
      @(negedge clock) check("t1_gnt_hold_until_edge", 128'(gnt_o), 128'(2'b01));
      tick();
      @(negedge clock) check("t1_idle", 128'(gnt_o), 128'(2'b00));

      // Tie right after reset: m0 first, one idle cycle, then m1, then m0 again
      tick();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      master(0, 1, 32'h100);
      master(1, 1, 32'h200);
      @(negedge clock) check("t2_idle_first", 128'(gnt_o), 128'(2'b00));
      tick();
      slave_ack(0, 32'hA000_0000);
      @(negedge clock);
      check("t2_tie_m0", 128'(gnt_o), 128'(2'b01));
      check("t2_adr_m0", 128'(s_adr_o), 128'(32'h100));
      tick();
      s_ack_i = 1'b0;
      master(0, 0, 32'h100);
      tick();
      @(negedge clock) check("t2_idle_gap", 128'(gnt_o), 128'(2'b00));
      tick();
      slave_ack(1, 32'hA000_0001);
      @(negedge clock);
      check("t2_then_m1", 128'(gnt_o), 128'(2'b10));
      check("t2_adr_m1", 128'(s_adr_o), 128'(32'h200));
      check("t2_route_m1", 128'({s_we_o, s_sel_o, s_dat_o}), 128'({1'b1, 4'h3, 32'h2222_0000}));
      tick();
      s_ack_i = 1'b0;
      master(1, 0, 32'h200);
      tick();
      master(0, 1, 32'h100);
      master(1, 1, 32'h200);
      tick();
      @(negedge clock) check("t2_tie2_m0", 128'(gnt_o), 128'(2'b01));
      tick();
      master(0, 0, 32'h100);
      master(1, 0, 32'h200);
      tick();
      @(negedge clock) check("t2_idle_end", 128'(gnt_o), 128'(2'b00));

      // Burst hold: m1 keeps cyc across four beats while m0 waits
      tick();
      master(1, 1, 32'h300);
      tick();
      master(0, 1, 32'h100);
      for (int k = 0; k < 4; k++) begin
         slave_ack(1, 32'hB000_0000 + 32'(k));
         @(negedge clock);
         check("t3_hold_beat", 128'(gnt_o), 128'(2'b10));
         check("t3_adr_m1", 128'(s_adr_o), 128'(32'h300));
         tick();
         s_ack_i = 1'b0;
         @(negedge clock) check("t3_hold_gap", 128'(gnt_o), 128'(2'b10));
         tick();
      end
      master(1, 0, 32'h300);
      tick();
      @(negedge clock) check("t3_idle", 128'(gnt_o), 128'(2'b00));
      tick();
      slave_ack(0, 32'hB100_0000);
      @(negedge clock) check("t3_m0_after", 128'(gnt_o), 128'(2'b01));
      tick();
      s_ack_i = 1'b0;
      master(0, 0, 32'h100);
      tick();

      // Timeout: slave never answers
      s_dat_i = '0;
      master(0, 1, 32'h400);
      tick();
      sb.push_back(resp(0, 1'b0, 1'b1, '0));
      for (int i = 0; i < TO; i++) begin
         @(negedge clock) check("t4_no_early_timeout", 128'({timeout_o, m0_err_o}), 128'(0));
         tick();
      end
      @(negedge clock);
      check("t4_timeout_pulse", 128'(timeout_o), 128'(1));
      check("t4_err", 128'(m0_err_o), 128'(1));
      check("t4_s_cyc_low", 128'(s_cyc_o), 128'(0));
      check("t4_gnt", 128'(gnt_o), 128'(2'b01));
      tick();
      master(0, 0, 32'h400);
      @(negedge clock);
      check("t4_regrant", 128'(gnt_o), 128'(2'b01));
      check("t4_pulse_one_cycle", 128'(timeout_o), 128'(0));
      tick();
      @(negedge clock) check("t4_idle", 128'(gnt_o), 128'(2'b00));

      // Boundary: ack in the last stall cycle completes normally
      tick();
      master(0, 1, 32'h500);
      tick();
      for (int i = 0; i < TO - 1; i++) begin
         @(negedge clock) check("t5_no_timeout", 128'(timeout_o), 128'(0));
         tick();
      end
      slave_ack(0, 32'hD00D_0008);
      @(negedge clock) check("t5_ack_at_limit", 128'({m0_ack_o, m0_err_o, timeout_o}), 128'(3'b100));
      tick();
      s_ack_i = 1'b0;
      master(0, 0, 32'h500);
      @(negedge clock) check("t5_no_abort", 128'({timeout_o, gnt_o}), 128'(3'b001));
      tick();

      // Reset asserted mid-transfer on m1
      master(1, 1, 32'h600);
      tick();
      @(negedge clock) check("t6_gnt1", 128'({gnt_o, s_cyc_o}), 128'(3'b101));
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_gnt", 128'(gnt_o), 128'(0));
      check("t6_async_s_cyc", 128'({s_cyc_o, s_stb_o, s_adr_o}), 128'(0));
      check("t6_no_err", 128'({m0_err_o, m1_err_o, timeout_o}), 128'(0));
      master(0, 1, 32'h100);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock) check("t6_idle_after", 128'(gnt_o), 128'(2'b00));
      tick();
      @(negedge clock) check("t6_tie_m0", 128'(gnt_o), 128'(2'b01));
      tick();
      master(0, 0, 32'h100);
      master(1, 0, 32'h600);
      repeat (2) tick();

      check("sb_empty", 128'(sb.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/marsohod_wb_arb2.md
MARSOHOD_WB_ARB2 -- requirements
Module: marsohod_wb_arb2

Interface
REQ-001 SHALL have parameter AW, default 32: Wishbone address width.
REQ-002 SHALL have parameter DW, default 32: Wishbone data width; select width is DW/8.
REQ-003 SHALL have parameter TIMEOUT, default 255: number of stalled strobe cycles before the arbiter aborts the access; legal range 1..65535.
REQ-004 SHALL have port clock, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have, for each master mN (N=0,1), inputs mN_adr_i AW, mN_dat_i DW, mN_sel_i DW/8, mN_we_i 1, mN_cyc_i 1, mN_stb_i 1: the master request.
REQ-007 SHALL have, for each mN, outputs mN_dat_o DW, mN_ack_o 1, mN_err_o 1: the master response.
REQ-008 SHALL have outputs s_adr_o AW, s_dat_o DW, s_sel_o DW/8, s_we_o 1, s_cyc_o 1, s_stb_o 1: the shared slave request.
REQ-009 SHALL have inputs s_dat_i DW, s_ack_i 1, s_err_i 1: the shared slave response.
REQ-010 SHALL have output gnt_o, 2 bits: one-hot current grant (bit0 = m0, bit1 = m1); 00 = idle.
REQ-011 SHALL have output timeout_o, 1 bit: one-cycle pulse on each aborted access.

Function
REQ-012 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT0, ABORT1, with registered state.
REQ-013 In IDLE with exactly one mN_cyc_i high, SHALL move to GNTN on the next edge (one cycle of arbitration latency).
REQ-014 In IDLE with both cyc high, SHALL grant the master not served last (round robin); the last-served flag SHALL reset to m1, so m0 wins the first tie.
REQ-015 In GNTN, SHALL hold the grant for as long as mN_cyc_i stays high, including across multiple stb/ack beats; the other master SHALL NOT preempt.
REQ-016 In GNTN, on the edge where mN_cyc_i is low, SHALL return to IDLE and update last-served to N; re-arbitration happens from IDLE, so there is at least one idle cycle between grants.
REQ-017 In GNTN, SHALL route mN_adr/dat/sel/we/cyc/stb to the s_* outputs and route s_dat_i/s_ack_i/s_err_i to mN_*; the mux SHALL be combinational from the registered state.
REQ-018 The non-granted master SHALL see dat_o=0, ack_o=0, err_o=0; in IDLE and ABORTN, all s_* request outputs SHALL be 0.
REQ-019 SHALL use a 16-bit stall counter that is cleared in IDLE, cleared on any s_ack_i or s_err_i, and cleared when the granted stb is low; otherwise it SHALL increment each cycle in GNTN.
REQ-020 When the stall counter equals TIMEOUT-1 and the slave gives no ack or err that cycle, SHALL go to ABORTN on the next edge.
REQ-021 ABORTN SHALL last exactly one cycle: it drives mN_err_o=1 and timeout_o=1 with s_cyc_o=0, then returns to GNTN if mN_cyc_i is still high, else to IDLE (updating last-served to N).
REQ-022 SHALL treat s_ack_i and s_err_i arriving in the same cycle that the counter reaches its limit as a normal completion (no abort).
REQ-023 SHALL ignore a slave ack or err arriving while in IDLE or ABORTN; nothing is forwarded.
REQ-024 gnt_o SHALL be 01 in GNT0/ABORT0, 10 in GNT1/ABORT1, and 00 in IDLE.

Reset
REQ-025 reset_n low SHALL, asynchronously, force IDLE, stall counter 0, last-served m1, gnt_o=00, and timeout_o=0, with all s_* request and mN_* response outputs 0.
REQ-026 Reset asserted mid-transfer SHALL drop s_cyc_o immediately with no err to either master; after release, arbitration restarts from IDLE on the first edge.

Verification
REQ-027 Single master: m0 cyc/stb, adr=0x100, slave acks after 2 cycles -> gnt_o=01 one cycle after cyc; m0_ack_o=1 in the same cycle as s_ack_i; IDLE one cycle after cyc drops.
REQ-028 Tie: m0 and m1 raise cyc in the same cycle after reset -> m0 is granted first; after m0 releases, m1 is granted after exactly one IDLE cycle; on the next tie, m0 wins.
REQ-029 Burst hold: m1 holds cyc for 4 stb/ack beats while m0 requests -> gnt_o stays 10 for all 4 beats; m0 sees no ack; m0 is granted only after m1 drops cyc.
REQ-030 Timeout: TIMEOUT=8, slave never acks -> m0_err_o and timeout_o pulse exactly 8 cycles after the first stb cycle; s_cyc_o=0 during the pulse.
REQ-031 Boundary: TIMEOUT=8, slave acks in the 8th stall cycle -> normal ack, with no err and no timeout_o.
REQ-032 Reset: assert reset_n low during a GNT1 transfer -> outputs reach 0 without waiting for a clock edge; after release, m0 wins a tie.
